// File: rtl/demux5_8r.sv
// Five-channel byte demultiplexer with per-channel hold registers and round-robin mode.
// Optional sticky illegal-select flag enabled by defining DEMUX5_8R_ERR_FLAG_EN.
module demux5_8r (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] sel,
    input  logic       auto,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [7:0] out4,
    output logic [4:0] out_valid,
    input  logic [4:0] out_ack,
    output logic [7:0] acc_cnt,
    output logic       err
);

    logic [2:0] rr_ptr;
    logic [2:0] tgt;
    logic [4:0] tgt_oh;
    logic [4:0] wr;
    logic       acc;
    logic [7:0] hold [5];

    // An illegal target decodes to no channel, so it is never blocked.
    always_comb begin
        tgt = auto ? rr_ptr : sel;
        for (int k = 0; k < 5; k++) begin
            tgt_oh[k] = (tgt == 3'(k));
        end
        in_ready = ~|(tgt_oh & out_valid & ~out_ack);
        acc      = in_valid & in_ready;
        wr       = acc ? tgt_oh : 5'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                hold[k] <= 8'h00;
            end
            out_valid <= 5'b0;
            rr_ptr    <= 3'd0;
            acc_cnt   <= 8'h00;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (wr[k]) begin
                    hold[k] <= in_data;
                end
            end
            out_valid <= wr | (out_valid & ~out_ack);
            if (acc) begin
                acc_cnt <= acc_cnt + 8'd1;
            end
            if (acc && auto) begin
                rr_ptr <= (rr_ptr == 3'd4) ? 3'd0 : rr_ptr + 3'd1;
            end
        end
    end

`ifdef DEMUX5_8R_ERR_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (acc && (tgt > 3'd4)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign out0 = hold[0];
    assign out1 = hold[1];
    assign out2 = hold[2];
    assign out3 = hold[3];
    assign out4 = hold[4];

endmodule

// File: tb/tb_demux5_8r.sv
// Self-checking bench for demux5_8r: reference model plus directed scenarios.
module tb_demux5_8r;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] sel = 3'd0;
    logic       auto = 1'b0;
    logic [7:0] out0, out1, out2, out3, out4;
    logic [4:0] out_valid;
    logic [4:0] out_ack = 5'b0;
    logic [7:0] acc_cnt;
    logic       err;

    int n_chk = 0;
    int n_fail = 0;

    demux5_8r dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sel(sel), .auto(auto),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out_valid(out_valid), .out_ack(out_ack),
        .acc_cnt(acc_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_data [5] = '{0, 0, 0, 0, 0};
    bit m_valid [5] = '{0, 0, 0, 0, 0};
    int m_cnt = 0;
    int m_rr = 0;
    bit m_err = 0;
    int m_t;
    bit m_acc;

    function automatic bit exp_ready();
        int t;
        t = auto ? m_rr : int'(sel);
        if (t > 4) return 1'b1;
        return !m_valid[t] || out_ack[t];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                m_data[k] = 0;
                m_valid[k] = 0;
            end
            m_cnt = 0;
            m_rr = 0;
            m_err = 0;
        end else begin
            m_t = auto ? m_rr : int'(sel);
            m_acc = in_valid && exp_ready();
            for (int k = 0; k < 5; k++) begin
                if (out_ack[k]) m_valid[k] = 0;
            end
            if (m_acc) begin
                m_cnt = (m_cnt + 1) % 256;
                if (m_t < 5) begin
                    m_data[m_t] = int'(in_data);
                    m_valid[m_t] = 1;
                end else begin
                    m_err = 1;
                end
                if (auto) m_rr = (m_rr + 1) % 5;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_vbits();
        logic [4:0] v;
        for (int k = 0; k < 5; k++) v[k] = m_valid[k];
        return v;
    endfunction

    always @(negedge clk) begin
        chk("out0", 32'(out0), 32'(m_data[0]));
        chk("out1", 32'(out1), 32'(m_data[1]));
        chk("out2", 32'(out2), 32'(m_data[2]));
        chk("out3", 32'(out3), 32'(m_data[3]));
        chk("out4", 32'(out4), 32'(m_data[4]));
        chk("out_valid", 32'(out_valid), 32'(m_vbits()));
        chk("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
`ifdef DEMUX5_8R_ERR_FLAG_EN
        chk("err", 32'(err), 32'(m_err));
`else
        chk("err", 32'(err), 32'd0);
`endif
        if (rst_n) chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input logic a, input logic [4:0] ack);
        in_valid = v;
        in_data = d;
        sel = s;
        auto = a;
        out_ack = ack;
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_cnt", 32'(acc_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed select, no acks
        put(1, 8'd2, 3'd0, 0, 5'b0); tick();
        put(1, 8'd4, 3'd1, 0, 5'b0); tick();
        put(1, 8'd8, 3'd2, 0, 5'b0); tick();
        put(1, 8'd16, 3'd3, 0, 5'b0); tick();
        put(1, 8'd32, 3'd4, 0, 5'b0); tick();
        put(0, 8'd0, 3'd0, 0, 5'b0);
        chk("s1_out0", 32'(out0), 32'd2);
        chk("s1_out2", 32'(out2), 32'd8);
        chk("s1_out4", 32'(out4), 32'd32);
        chk("s1_valid", 32'(out_valid), 32'h1f);
        chk("s1_cnt", 32'(acc_cnt), 32'd5);

        // Backpressure on full channel 2, then same-cycle ack
        put(1, 8'd99, 3'd2, 0, 5'b0);
        #2 chk("s2_blocked", 32'(in_ready), 32'd0);
        tick();
        chk("s2_hold", 32'(out2), 32'd8);
        put(1, 8'd99, 3'd2, 0, 5'b00100);
        #2 chk("s2_ready", 32'(in_ready), 32'd1);
        tick();
        chk("s2_out2", 32'(out2), 32'd99);
        chk("s2_v2", 32'(out_valid[2]), 32'd1);

        // Drain all, then ack on empty channels
        put(0, 8'd0, 3'd0, 0, 5'h1f); tick();
        put(0, 8'd0, 3'd0, 0, 5'h1f); tick();
        chk("drain", 32'(out_valid), 32'd0);

        // Round-robin with all acks asserted
        for (int i = 0; i < 7; i++) begin
            put(1, 8'(10 + i), 3'd7, 1, 5'h1f);
            tick();
        end
        put(0, 8'd0, 3'd0, 0, 5'b0);
        chk("s3_out0", 32'(out0), 32'd15);
        chk("s3_out1", 32'(out1), 32'd16);
        chk("s3_out4", 32'(out4), 32'd14);
        chk("s3_cnt", 32'(acc_cnt), 32'd13);

        // Illegal select is consumed and discarded
        put(1, 8'd55, 3'd6, 0, 5'b0);
        #2 chk("s4_ready", 32'(in_ready), 32'd1);
        tick();
        put(0, 8'd0, 3'd0, 0, 5'b0);
        chk("s4_cnt", 32'(acc_cnt), 32'd14);
        chk("s4_out0", 32'(out0), 32'd15);
`ifdef DEMUX5_8R_ERR_FLAG_EN
        chk("s4_err", 32'(err), 32'd1);
`else
        chk("s4_err", 32'(err), 32'd0);
`endif

        // Auto-mode switch mid-stream keeps pointer (2 -> 3)
        put(1, 8'd60, 3'd0, 1, 5'h1f); tick();
        chk("s5_out2", 32'(out2), 32'd60);
        for (int i = 0; i < 3; i++) begin
            put(1, 8'(70 + i), 3'd0, 1, 5'h1f);
            tick();
        end
        put(0, 8'd0, 3'd0, 0, 5'b0);
        chk("s5_out3", 32'(out3), 32'd70);
        chk("s5_out0", 32'(out0), 32'd72);
        #3 rst_n = 1'b0;
        #1;
        chk("r_out0", 32'(out0), 32'd0);
        chk("r_out3", 32'(out3), 32'd0);
        chk("r_valid", 32'(out_valid), 32'd0);
        chk("r_cnt", 32'(acc_cnt), 32'd0);
        chk("r_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        put(1, 8'd77, 3'd3, 1, 5'b0); tick();
        put(0, 8'd0, 3'd0, 0, 5'b0);
        chk("r_first", 32'(out0), 32'd77);
        chk("r_fvalid", 32'(out_valid), 32'd1);

        // Counter wrap from a clean reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        put(1, 8'd1, 3'd5, 0, 5'b0);
        for (int i = 0; i < 255; i++) tick();
        chk("w_255", 32'(acc_cnt), 32'd255);
        tick();
        put(0, 8'd0, 3'd0, 0, 5'b0);
        chk("w_0", 32'(acc_cnt), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux5_8r.md
DEMUX5_8R -- requirements
Module: demux5_8r

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: source offers in_data.
REQ-004 The block SHALL have the port in_ready, output, 1 bit: block accepts in_data this cycle (combinational).
REQ-005 The block SHALL have the port in_data, input, 8 bits: payload byte.
REQ-006 The block SHALL have the port sel, input, 3 bits: destination channel when auto=0; legal values are 0-4.
REQ-007 The block SHALL have the port auto, input, 1 bit: 1 means the destination is the internal round-robin pointer and sel is ignored.
REQ-008 The block SHALL have the ports out0, out1, out2, out3 and out4, each output, 8 bits: per-channel hold registers.
REQ-009 The block SHALL have the port out_valid, output, 5 bits: bit k set means outk holds unread data.
REQ-010 The block SHALL have the port out_ack, input, 5 bits: bit k means the consumer takes outk this cycle.
REQ-011 The block SHALL have the port acc_cnt, output, 8 bits: count of accepted bytes, wrapping.
REQ-012 The block SHALL have the port err, output, 1 bit: sticky illegal-select flag (see Configuration).

Function
REQ-013 Target tgt SHALL be defined as rr_ptr when auto=1, else sel.
REQ-014 in_ready SHALL be 1 when tgt>4, or when !out_valid[tgt] or out_ack[tgt]; otherwise 0.
REQ-015 Accept SHALL be in_valid && in_ready; data on a legal tgt SHALL appear on out<tgt> with out_valid[tgt]=1 one cycle after accept.
REQ-016 Other channels' data and valid bits SHALL be unchanged by an accept.
REQ-017 out_ack[k] with out_valid[k]=1 and no same-cycle write to k SHALL clear out_valid[k] next cycle; outk SHALL keep its last value.
REQ-018 out_ack[k] with out_valid[k]=0 SHALL be ignored.
REQ-019 Simultaneous ack and write on the same channel SHALL load the new byte and keep out_valid[k]=1.
REQ-020 rr_ptr (3 bits) SHALL advance by 1 on each accept with auto=1, wrapping 4->0; it SHALL hold when auto=0.
REQ-021 A change of auto mid-stream SHALL take effect on the same cycle without resetting rr_ptr.
REQ-022 An accept with illegal tgt (5-7, auto=0 only) SHALL consume and discard the byte.
REQ-023 acc_cnt SHALL increment on every accept, legal or illegal, wrapping 255->0.

Reset
REQ-024 rst_n=0 SHALL immediately force out0-out4=0, out_valid=0, rr_ptr=0, acc_cnt=0 and err=0, regardless of clk.
REQ-025 Reset asserted mid-transfer SHALL drop all held data; the first accept after release SHALL go to channel 0 when auto=1.

Configuration
REQ-026 Macro DEMUX5_8R_ERR_FLAG_EN defined: err SHALL set on the cycle after an illegal-tgt accept and stay 1 until reset.
REQ-027 Macro DEMUX5_8R_ERR_FLAG_EN undefined: err SHALL be tied 0 and no flag register is built; discard behaviour SHALL be unchanged.

Verification
REQ-028 Scenario: auto=0; send sel=0..4 with data 2,4,8,16,32 and no acks -> out0..out4=2,4,8,16,32, out_valid=5'b11111, acc_cnt=5.
REQ-029 Scenario: with channel 2 full, offer sel=2 data 99 and no ack -> in_ready=0 and out2 stays 8; assert out_ack[2] the same cycle -> accept, out2=99, out_valid[2]=1.
REQ-030 Scenario: auto=1; send 7 bytes 10..16 with all out_ack=1 -> destinations 0,1,2,3,4,0,1; final out0=15, out1=16.
REQ-031 Scenario: auto=0, sel=6, data 55 -> in_ready=1, no outk changes, acc_cnt increments, err=1 with the macro and 0 without.
REQ-032 Scenario: assert rst_n=0 between clock edges after 3 auto-mode accepts -> all outputs become 0 at once; the next accept lands in out0.
REQ-033 Scenario: send 256 accepts -> acc_cnt wraps to 0.
